// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the IF/MEM bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } owner_t;

  localparam logic [3:0] FETCH_SEL = 4'b1111;

endpackage

// File: rtl/mem_bus_grant.sv
// Fixed-priority select between the data port and instruction fetch.
// Produces the grant and the bus fields to latch at issue time.
module mem_bus_grant
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              data_pend_i,
  input  logic              inst_pend_i,
  input  logic              ram_we_i,
  input  logic [3:0]        ram_sel_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [DATA_W-1:0] ram_wdata_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              grant_o,
  output owner_t            owner_o,
  output logic              wr_o,
  output logic [3:0]        sel_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o
);

  always_comb begin
    grant_o = data_pend_i | inst_pend_i;
    if (data_pend_i) begin
      owner_o = OWN_DATA;
      wr_o    = ram_we_i;
      sel_o   = ram_sel_i;
      addr_o  = ram_addr_i;
      wdata_o = ram_wdata_i;
    end else begin
      owner_o = OWN_INST;
      wr_o    = 1'b0;
      sel_o   = FETCH_SEL;
      addr_o  = inst_addr_i;
      wdata_o = '0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one addr_ok/data_ok bus port between IF and MEM, data first,
// and raises the pipeline stall while either requester is unserved.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_valid_o,
  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [3:0]        ram_sel_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [DATA_W-1:0] ram_wdata_i,
  output logic [DATA_W-1:0] ram_rdata_o,
  output logic              data_valid_o,
  input  logic              pipe_stall_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              bus_req_o,
  output logic              bus_wr_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_addr_ok_i,
  input  logic              bus_data_ok_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  state_t            state_q;
  owner_t            owner_q;
  logic              data_done_q;
  logic              inst_done_q;
  logic              discard_q;
  logic              bus_req_q;
  logic              bus_wr_q;
  logic [3:0]        bus_sel_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] ram_rdata_q;
  logic              inst_valid_q;
  logic              data_valid_q;

  logic              data_pend;
  logic              inst_pend;
  logic              clear_done;
  logic              grant;
  owner_t            g_owner;
  logic              g_wr;
  logic [3:0]        g_sel;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  assign data_pend   = ram_ce_i & ~data_done_q;
  assign inst_pend   = inst_req_i & ~inst_done_q & ~flush_i;
  assign stall_req_o = ~rst_i & (data_pend | inst_pend);
  // Done flags only hold off reissue while the pipeline is frozen on this instruction.
  assign clear_done  = (~stall_req_o & ~pipe_stall_i) | flush_i;

  mem_bus_grant #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_grant (
    .data_pend_i (data_pend),
    .inst_pend_i (inst_pend),
    .ram_we_i    (ram_we_i),
    .ram_sel_i   (ram_sel_i),
    .ram_addr_i  (ram_addr_i),
    .ram_wdata_i (ram_wdata_i),
    .inst_addr_i (inst_addr_i),
    .grant_o     (grant),
    .owner_o     (g_owner),
    .wr_o        (g_wr),
    .sel_o       (g_sel),
    .addr_o      (g_addr),
    .wdata_o     (g_wdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      data_done_q  <= 1'b0;
      inst_done_q  <= 1'b0;
      discard_q    <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_sel_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      ram_rdata_q  <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      if (clear_done) begin
        data_done_q <= 1'b0;
        inst_done_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q     <= g_owner;
            bus_wr_q    <= g_wr;
            bus_sel_q   <= g_sel;
            bus_addr_q  <= g_addr;
            bus_wdata_q <= g_wdata;
            bus_req_q   <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (flush_i && owner_q == OWN_INST) discard_q <= 1'b1;
          if (bus_addr_ok_i) begin
            bus_req_q <= 1'b0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (bus_data_ok_i) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            if (owner_q == OWN_DATA) begin
              if (!bus_wr_q) ram_rdata_q <= bus_rdata_i;
              data_valid_q <= 1'b1;
              data_done_q  <= 1'b1;
            end else if (!discard_q && !flush_i) begin
              inst_rdata_q <= bus_rdata_i;
              inst_valid_q <= 1'b1;
              inst_done_q  <= 1'b1;
            end
          end else if (flush_i && owner_q == OWN_INST) begin
            discard_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req_o    = bus_req_q;
  assign bus_wr_o     = bus_wr_q;
  assign bus_sel_o    = bus_sel_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_wdata_o  = bus_wdata_q;
  assign inst_rdata_o = inst_rdata_q;
  assign ram_rdata_o  = ram_rdata_q;
  assign inst_valid_o = inst_valid_q;
  assign data_valid_o = data_valid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: the main process drives requesters and acts as bus slave,
// a monitor process compares every bus issue, valid pulse and directed probe.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          inst_req_i;
  logic [AW-1:0] inst_addr_i;
  logic [DW-1:0] inst_rdata_o;
  logic          inst_valid_o;
  logic          ram_ce_i;
  logic          ram_we_i;
  logic [3:0]    ram_sel_i;
  logic [AW-1:0] ram_addr_i;
  logic [DW-1:0] ram_wdata_i;
  logic [DW-1:0] ram_rdata_o;
  logic          data_valid_o;
  logic          pipe_stall_i;
  logic          flush_i;
  logic          stall_req_o;
  logic          bus_req_o;
  logic          bus_wr_o;
  logic [3:0]    bus_sel_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic          bus_addr_ok_i;
  logic          bus_data_ok_i;
  logic [DW-1:0] bus_rdata_i;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
    .inst_rdata_o(inst_rdata_o), .inst_valid_o(inst_valid_o),
    .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
    .ram_addr_i(ram_addr_i), .ram_wdata_i(ram_wdata_i),
    .ram_rdata_o(ram_rdata_o), .data_valid_o(data_valid_o),
    .pipe_stall_i(pipe_stall_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
    .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_addr_ok_i(bus_addr_ok_i), .bus_data_ok_i(bus_data_ok_i),
    .bus_rdata_i(bus_rdata_i)
  );

  typedef struct packed {
    logic          is_data;
    logic          wr;
    logic [3:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          exp_bus[$];
  txn_t          serve_q[$];
  logic [DW-1:0] exp_inst[$];
  logic [DW-1:0] exp_data[$];
  string         pr_name[$];
  logic [63:0]   pr_act[$];
  logic [63:0]   pr_exp[$];

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] last_ram;
  logic [DW-1:0] last_inst;
  int            last_wait;

  task automatic probe(input string nm, input logic [63:0] act, input logic [63:0] ex);
    pr_name.push_back(nm);
    pr_act.push_back(act);
    pr_exp.push_back(ex);
  endtask

  // Monitor: sole owner of the comparison counters.
  initial begin
    logic prev_req;
    txn_t cap;
    txn_t e;
    string nm;
    logic [63:0] a;
    logic [63:0] x;
    prev_req = 1'b0;
    cap = '0;
    forever begin
      @(negedge clk);
      while (pr_name.size() > 0) begin
        nm = pr_name.pop_front();
        a  = pr_act.pop_front();
        x  = pr_exp.pop_front();
        n_cmp++;
        if (a !== x) begin
          n_bad++;
          $display("FAIL %s actual=%0h required=%0h", nm, a, x);
        end
      end
      if (bus_req_o && !prev_req) begin
        n_cmp++;
        cap = '{is_data: 1'b0, wr: bus_wr_o, sel: bus_sel_o, addr: bus_addr_o, wdata: bus_wdata_o};
        if (exp_bus.size() == 0) begin
          n_bad++;
          $display("FAIL bus_issue actual=addr %h required=no request", bus_addr_o);
        end else begin
          e = exp_bus.pop_front();
          if (bus_wr_o !== e.wr || bus_sel_o !== e.sel || bus_addr_o !== e.addr ||
              (e.wr && bus_wdata_o !== e.wdata)) begin
            n_bad++;
            $display("FAIL bus_issue actual=wr%b sel%b addr%h wd%h required=wr%b sel%b addr%h wd%h",
                     bus_wr_o, bus_sel_o, bus_addr_o, bus_wdata_o, e.wr, e.sel, e.addr, e.wdata);
          end
        end
      end else if (bus_req_o) begin
        n_cmp++;
        if (bus_wr_o !== cap.wr || bus_sel_o !== cap.sel || bus_addr_o !== cap.addr ||
            bus_wdata_o !== cap.wdata) begin
          n_bad++;
          $display("FAIL bus_hold actual=addr %h sel %b required=addr %h sel %b",
                   bus_addr_o, bus_sel_o, cap.addr, cap.sel);
        end
      end
      prev_req = bus_req_o;
      if (inst_valid_o) begin
        n_cmp++;
        if (exp_inst.size() == 0) begin
          n_bad++;
          $display("FAIL inst_valid actual=pulse data %h required=no pulse", inst_rdata_o);
        end else begin
          x[DW-1:0] = exp_inst.pop_front();
          if (inst_rdata_o !== x[DW-1:0]) begin
            n_bad++;
            $display("FAIL inst_rdata actual=%h required=%h", inst_rdata_o, x[DW-1:0]);
          end
        end
      end
      if (data_valid_o) begin
        n_cmp++;
        if (exp_data.size() == 0) begin
          n_bad++;
          $display("FAIL data_valid actual=pulse data %h required=no pulse", ram_rdata_o);
        end else begin
          x[DW-1:0] = exp_data.pop_front();
          if (ram_rdata_o !== x[DW-1:0]) begin
            n_bad++;
            $display("FAIL ram_rdata actual=%h required=%h", ram_rdata_o, x[DW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic issue_data(input logic we, input logic [3:0] sel, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd);
    txn_t t;
    ram_ce_i = 1'b1; ram_we_i = we; ram_sel_i = sel; ram_addr_i = addr; ram_wdata_i = wd;
    t = '{is_data: 1'b1, wr: we, sel: sel, addr: addr, wdata: wd};
    exp_bus.push_back(t);
    serve_q.push_back(t);
  endtask

  task automatic issue_inst(input logic [AW-1:0] addr);
    txn_t t;
    inst_req_i = 1'b1; inst_addr_i = addr;
    t = '{is_data: 1'b0, wr: 1'b0, sel: 4'b1111, addr: addr, wdata: '0};
    exp_bus.push_back(t);
    serve_q.push_back(t);
  endtask

  task automatic wait_req();
    int w;
    w = 0;
    while (!bus_req_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    probe("bus_req_seen", {63'd0, bus_req_o}, 64'd1);
  endtask

  // Bus slave for one transaction; flush_mode 1 = flush in RESP, 2 = flush with data_ok.
  task automatic serve_one(input int a_dly, input int d_dly, input int flush_mode,
                           input logic [DW-1:0] rdata);
    txn_t t;
    t = serve_q.pop_front();
    wait_req();
    if (!bus_req_o) return;
    repeat (a_dly) begin
      probe("req_held", {63'd0, bus_req_o}, 64'd1);
      probe("stall_busy", {63'd0, stall_req_o}, 64'd1);
      @(negedge clk);
    end
    bus_addr_ok_i = 1'b1;
    @(negedge clk);
    bus_addr_ok_i = 1'b0;
    probe("req_dropped", {63'd0, bus_req_o}, 64'd0);
    if (flush_mode == 1) begin
      flush_i = 1'b1; inst_req_i = 1'b0;
      @(negedge clk);
      flush_i = 1'b0;
    end
    repeat (d_dly) @(negedge clk);
    bus_rdata_i = rdata;
    bus_data_ok_i = 1'b1;
    if (flush_mode == 2) begin
      flush_i = 1'b1; inst_req_i = 1'b0;
    end
    if (t.is_data) begin
      if (!t.wr) last_ram = rdata;
      exp_data.push_back(last_ram);
    end else if (flush_mode == 0) begin
      last_inst = rdata;
      exp_inst.push_back(rdata);
    end
    @(negedge clk);
    bus_data_ok_i = 1'b0;
    flush_i = 1'b0;
  endtask

  // Pipeline stays held for a while (no reissue allowed), then advances one edge.
  task automatic finish_step(input int hold);
    probe("stall_after_serve", {63'd0, stall_req_o}, 64'd0);
    repeat (hold) @(negedge clk);
    pipe_stall_i = 1'b0;
    @(negedge clk);
    ram_ce_i = 1'b0; inst_req_i = 1'b0; pipe_stall_i = 1'b1;
  endtask

  initial begin
    logic dd, di, we;
    rst_i = 1'b1; inst_req_i = 1'b1; inst_addr_i = '0; ram_ce_i = 1'b1; ram_we_i = 1'b0;
    ram_sel_i = '0; ram_addr_i = '0; ram_wdata_i = '0; pipe_stall_i = 1'b1; flush_i = 1'b0;
    bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b0; bus_rdata_i = '0;
    last_ram = '0; last_inst = '0; last_wait = 0;
    repeat (3) @(negedge clk);
    probe("rst_stall", {63'd0, stall_req_o}, 64'd0);
    probe("rst_bus_req", {63'd0, bus_req_o}, 64'd0);
    probe("rst_rdata", {inst_rdata_o, ram_rdata_o}, 64'd0);
    inst_req_i = 1'b0; ram_ce_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // Fetch only, then held pipeline must not reissue.
    issue_inst(32'hBFC00000);
    serve_one(0, 1, 0, 32'h3C080001);
    probe("fetch_rdata", {32'd0, inst_rdata_o}, {32'd0, 32'h3C080001});
    finish_step(4);

    // Data write and fetch together: data first, fetch after one idle cycle.
    issue_data(1'b1, 4'b0011, 32'h80000010, 32'h0000BEEF);
    issue_inst(32'hBFC00004);
    serve_one(1, 0, 0, 32'h12345678);
    serve_one(0, 0, 0, 32'h24020005);
    probe("fetch_gap", 64'(last_wait), 64'd1);
    finish_step(2);

    // addr_ok backpressure.
    issue_inst(32'hBFC00008);
    serve_one(5, 1, 0, 32'hAAAA5555);
    finish_step(0);

    // Flush while in RESP, then flush coinciding with data_ok.
    issue_inst(32'hBFC00100);
    serve_one(0, 2, 1, 32'hDEAD0001);
    @(negedge clk);
    probe("flush_keep_rdata", {32'd0, inst_rdata_o}, {32'd0, last_inst});
    issue_inst(32'hBFC00380);
    serve_one(0, 1, 0, 32'h40806000);
    finish_step(1);
    issue_inst(32'hBFC00400);
    serve_one(1, 0, 2, 32'hDEAD0002);
    @(negedge clk);
    probe("flush_same_edge", {32'd0, inst_rdata_o}, {32'd0, last_inst});
    finish_step(0);

    // Stray handshakes in IDLE.
    bus_data_ok_i = 1'b1; bus_addr_ok_i = 1'b1; bus_rdata_i = 32'hFFFF0000;
    @(negedge clk);
    bus_data_ok_i = 1'b0; bus_addr_ok_i = 1'b0;
    probe("stray_valid", {62'd0, inst_valid_o, data_valid_o}, 64'd0);
    probe("stray_req", {63'd0, bus_req_o}, 64'd0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      dd = 1'($urandom_range(0, 1));
      di = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      if (!dd && !di) di = 1'b1;
      if (dd) issue_data(we, 4'($urandom), {$urandom} & 32'hFFFFFFFC, $urandom);
      if (di) issue_inst({$urandom} & 32'hFFFFFFFC);
      if (dd) serve_one($urandom_range(0, 3), $urandom_range(0, 3), 0, $urandom);
      if (di) serve_one($urandom_range(0, 3), $urandom_range(0, 3), 0, $urandom);
      finish_step($urandom_range(0, 3));
    end

    // Reset while in REQ, then a late data_ok.
    issue_inst(32'hBFC00500);
    void'(serve_q.pop_front());
    wait_req();
    @(negedge clk);
    rst_i = 1'b1; inst_req_i = 1'b0;
    @(negedge clk);
    probe("rstmid_bus_req", {63'd0, bus_req_o}, 64'd0);
    probe("rstmid_bus", {bus_wr_o, bus_sel_o, bus_addr_o}, 64'd0);
    probe("rstmid_wdata", {32'd0, bus_wdata_o}, 64'd0);
    probe("rstmid_rdata", {inst_rdata_o, ram_rdata_o}, 64'd0);
    probe("rstmid_flags", {61'd0, inst_valid_o, data_valid_o, stall_req_o}, 64'd0);
    rst_i = 1'b0; last_inst = '0; last_ram = '0;
    @(negedge clk);
    bus_data_ok_i = 1'b1;
    @(negedge clk);
    bus_data_ok_i = 1'b0;
    probe("late_data_ok", {62'd0, inst_valid_o, data_valid_o}, 64'd0);

    repeat (2) @(negedge clk);
    probe("bus_queue_left", 64'(exp_bus.size()), 64'd0);
    probe("inst_queue_left", 64'(exp_inst.size()), 64'd0);
    probe("data_queue_left", 64'(exp_data.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
